// File: rtl/snax_hwpe_pkg.sv
// Shared types, constants and helpers for the reqrsp-to-HWPE TCDM bridge.
// Holds the reqrsp channel structs, the bridge FSM states and the HWPE word-address helper.
package snax_hwpe_pkg;

    localparam int HwpeDataWidth = 32;
    localparam int HwpeBeWidth   = 4;

    localparam int ReqAddrWidth = 48;
    localparam int ReqDataWidth = 64;
    localparam int ReqStrbWidth = ReqDataWidth / 8;

    typedef enum logic [2:0] {
        IDLE,
        LO,
        HI,
        WAIT,
        RESP
    } r2h_state_e;

    typedef struct packed {
        logic [ReqAddrWidth-1:0] addr;
        logic                    write;
        logic [3:0]              amo;
        logic [ReqDataWidth-1:0] data;
        logic [ReqStrbWidth-1:0] strb;
        logic [0:0]              user;
    } reqrsp_q_chan_t;

    typedef struct packed {
        reqrsp_q_chan_t q;
        logic           q_valid;
    } reqrsp_req_t;

    typedef struct packed {
        logic [ReqDataWidth-1:0] data;
    } reqrsp_p_chan_t;

    typedef struct packed {
        reqrsp_p_chan_t p;
        logic           p_valid;
        logic           q_ready;
    } reqrsp_rsp_t;

    // One buffered request: only the fields the bridge actually forwards.
    typedef struct packed {
        logic [31:3]             addr;
        logic                    write;
        logic [ReqDataWidth-1:0] data;
        logic [ReqStrbWidth-1:0] strb;
    } r2h_entry_t;

    function automatic logic [31:0] hwpe_word_addr(input logic [31:3] addr, input logic hi);
        return {addr, hi, 2'b00};
    endfunction

endpackage

// File: rtl/hwpe_stream_intf_tcdm.sv
// HWPE TCDM port bundle: request/grant handshake plus single-cycle-later read response.
interface hwpe_stream_intf_tcdm;
    import snax_hwpe_pkg::*;

    logic                     req;
    logic                     gnt;
    logic [31:0]              add;
    logic                     wen;
    logic [HwpeBeWidth-1:0]   be;
    logic [HwpeDataWidth-1:0] data;
    logic [HwpeDataWidth-1:0] r_data;
    logic                     r_valid;

    modport master (output req, add, wen, be, data, input gnt, r_data, r_valid);
    modport slave  (input req, add, wen, be, data, output gnt, r_data, r_valid);

endinterface

// File: rtl/fifo_v3.sv
// Small circular-buffer FIFO used as the bridge request buffer.
// FALL_THROUGH=1 forwards data_i to data_o combinationally while empty.
module fifo_v3 #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    output logic                  full_o,
    output logic                  empty_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  push_i,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  pop_i
);

    localparam int unsigned PtrWidth = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntWidth = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PtrWidth-1:0]   r_rd_ptr;
    logic [PtrWidth-1:0]   r_wr_ptr;
    logic [CntWidth-1:0]   r_cnt;

    logic w_is_empty;
    logic w_fall;
    logic w_bypass;
    logic w_wr;
    logic w_rd;

    assign w_is_empty = (r_cnt == '0);
    assign full_o     = (r_cnt == CntWidth'(DEPTH));
    assign w_fall     = FALL_THROUGH && w_is_empty && push_i;
    assign empty_o    = w_is_empty && !w_fall;
    assign data_o     = (FALL_THROUGH && w_is_empty) ? data_i : r_mem[r_rd_ptr];

    // A fall-through entry consumed in the same cycle never touches storage.
    assign w_bypass = w_fall && pop_i;
    assign w_wr     = push_i && !full_o && !w_bypass;
    assign w_rd     = pop_i && !w_is_empty;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_cnt    <= '0;
        end else if (flush_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= (r_wr_ptr == PtrWidth'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= (r_rd_ptr == PtrWidth'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // NOTE: storage has no reset; the count and pointers alone decide which entries are valid.
    always_ff @(posedge clk_i) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

endmodule

// File: rtl/snax_reqrsp_to_hwpe.sv
// Bridge from a 64-bit reqrsp TCDM port to a 32-bit HWPE TCDM master, one request in flight.
// Optional macro SNAX_REQRSP_TO_HWPE_STRB_SKIP_EN: skip write halves whose strobe nibble is zero.
module snax_reqrsp_to_hwpe
    import snax_hwpe_pkg::*;
#(
    parameter int  AddrWidth  = 48,
    parameter int  DataWidth  = 64,
    parameter int  FifoDepth  = 2,
    parameter type tcdm_req_t = snax_hwpe_pkg::reqrsp_req_t,
    parameter type tcdm_rsp_t = snax_hwpe_pkg::reqrsp_rsp_t
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  tcdm_req_t                   tcdm_req_i,
    output tcdm_rsp_t                   tcdm_rsp_o,
    hwpe_stream_intf_tcdm.master        hwpe_tcdm_master
);

    localparam int EntryWidth = $bits(r2h_entry_t);

    r2h_state_e r_state;
    r2h_state_e w_state_nxt;

    logic [HwpeDataWidth-1:0] r_lo_q;
    logic [HwpeDataWidth-1:0] r_hi_q;
    logic                     r_lo_pend;
    logic                     r_hi_pend;

    r2h_entry_t            w_push_entry;
    r2h_entry_t            w_head;
    logic [EntryWidth-1:0] w_head_raw;

    logic w_full;
    logic w_empty;
    logic w_q_ready;
    logic w_push;
    logic w_pop;
    logic w_need_lo;
    logic w_need_hi;
    logic w_unused;

    logic                     w_req;
    logic [31:0]              w_add;
    logic                     w_wen;
    logic [HwpeBeWidth-1:0]   w_be;
    logic [HwpeDataWidth-1:0] w_data;

    assign w_push_entry.addr  = tcdm_req_i.q.addr[31:3];
    assign w_push_entry.write = tcdm_req_i.q.write;
    assign w_push_entry.data  = tcdm_req_i.q.data[DataWidth-1:0];
    assign w_push_entry.strb  = tcdm_req_i.q.strb;

    // Upper address bits, byte offset, amo and user have no meaning on the HWPE side.
    assign w_unused = ^{tcdm_req_i.q.addr[AddrWidth-1:32], tcdm_req_i.q.addr[2:0],
                        tcdm_req_i.q.amo, tcdm_req_i.q.user};

    // Held low throughout reset so an initiator never sees a handshake it cannot complete.
    assign w_q_ready = rst_ni && !w_full;
    assign w_push    = tcdm_req_i.q_valid && w_q_ready;

    fifo_v3 #(
        .FALL_THROUGH (1'b0),
        .DATA_WIDTH   (EntryWidth),
        .DEPTH        (FifoDepth)
    ) i_req_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (1'b0),
        .full_o  (w_full),
        .empty_o (w_empty),
        .data_i  (w_push_entry),
        .push_i  (w_push),
        .data_o  (w_head_raw),
        .pop_i   (w_pop)
    );

    assign w_head = r2h_entry_t'(w_head_raw);

`ifdef SNAX_REQRSP_TO_HWPE_STRB_SKIP_EN
    assign w_need_lo = !w_head.write || (|w_head.strb[3:0]);
    assign w_need_hi = !w_head.write || (|w_head.strb[7:4]);
`else
    assign w_need_lo = 1'b1;
    assign w_need_hi = 1'b1;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_add       = '0;
        w_wen       = 1'b0;
        w_be        = '0;
        w_data      = '0;
        w_pop       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    if (w_need_lo) begin
                        w_state_nxt = LO;
                    end else if (w_need_hi) begin
                        w_state_nxt = HI;
                    end else begin
                        w_state_nxt = RESP;
                    end
                end
            end
            LO: begin
                w_req  = 1'b1;
                w_add  = hwpe_word_addr(w_head.addr, 1'b0);
                w_wen  = !w_head.write;
                w_be   = w_head.strb[3:0];
                w_data = w_head.data[31:0];
                if (hwpe_tcdm_master.gnt) begin
                    if (w_need_hi) begin
                        w_state_nxt = HI;
                    end else begin
                        w_state_nxt = w_head.write ? RESP : WAIT;
                    end
                end
            end
            HI: begin
                w_req  = 1'b1;
                w_add  = hwpe_word_addr(w_head.addr, 1'b1);
                w_wen  = !w_head.write;
                w_be   = w_head.strb[7:4];
                w_data = w_head.data[63:32];
                if (hwpe_tcdm_master.gnt) begin
                    w_state_nxt = w_head.write ? RESP : WAIT;
                end
            end
            WAIT: begin
                w_state_nxt = RESP;
            end
            RESP: begin
                w_pop       = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Pending flags tie each r_valid to the half whose read grant preceded it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_lo_q    <= '0;
            r_hi_q    <= '0;
            r_lo_pend <= 1'b0;
            r_hi_pend <= 1'b0;
        end else begin
            if (r_state == RESP) begin
                r_lo_q <= '0;
                r_hi_q <= '0;
            end
            if (hwpe_tcdm_master.r_valid) begin
                if (r_lo_pend) begin
                    r_lo_q    <= hwpe_tcdm_master.r_data;
                    r_lo_pend <= 1'b0;
                end else if (r_hi_pend) begin
                    r_hi_q    <= hwpe_tcdm_master.r_data;
                    r_hi_pend <= 1'b0;
                end
            end
            if ((r_state == LO) && hwpe_tcdm_master.gnt && !w_head.write) begin
                r_lo_pend <= 1'b1;
            end
            if ((r_state == HI) && hwpe_tcdm_master.gnt && !w_head.write) begin
                r_hi_pend <= 1'b1;
            end
        end
    end

    assign hwpe_tcdm_master.req  = w_req;
    assign hwpe_tcdm_master.add  = w_add;
    assign hwpe_tcdm_master.wen  = w_wen;
    assign hwpe_tcdm_master.be   = w_be;
    assign hwpe_tcdm_master.data = w_data;

    always_comb begin
        tcdm_rsp_o         = '0;
        tcdm_rsp_o.q_ready = w_q_ready;
        tcdm_rsp_o.p_valid = (r_state == RESP);
        if ((r_state == RESP) && !w_head.write) begin
            tcdm_rsp_o.p.data = {r_hi_q, r_lo_q};
        end
    end

endmodule

// File: tb/tb_snax_reqrsp_to_hwpe.sv
// Directed bench for snax_reqrsp_to_hwpe: reads, writes, grant stalls, FIFO backpressure, mid-op reset.
// A negedge-driven HWPE responder logs every granted transaction and every response pulse.
module tb_snax_reqrsp_to_hwpe;
    import snax_hwpe_pkg::*;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    reqrsp_req_t tcdm_req;
    reqrsp_rsp_t tcdm_rsp;
    hwpe_stream_intf_tcdm hwpe_if ();

    snax_reqrsp_to_hwpe dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .tcdm_req_i       (tcdm_req),
        .tcdm_rsp_o       (tcdm_rsp),
        .hwpe_tcdm_master (hwpe_if)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    logic        gnt_en       = 1'b1;
    logic        force_rvalid = 1'b0;
    logic        rd_pend      = 1'b0;
    logic [31:0] rd_word      = '0;
    logic [31:0] mem [logic [31:0]];

    logic [31:0] log_add  [64];
    logic        log_wen  [64];
    logic [3:0]  log_be   [64];
    logic [31:0] log_data [64];
    int          log_cyc  [64];
    int          log_cnt = 0;
    logic [63:0] rsp_data [16];
    int          rsp_cyc  [16];
    int          rsp_cnt = 0;

    // HWPE slave model: grant from gnt_en, read data one cycle after each read grant.
    initial begin
        hwpe_if.gnt     = 1'b0;
        hwpe_if.r_valid = 1'b0;
        hwpe_if.r_data  = '0;
        forever begin
            @(negedge clk_i);
            hwpe_if.r_valid = rd_pend || force_rvalid;
            hwpe_if.r_data  = force_rvalid ? 32'hdead_beef : rd_word;
            hwpe_if.gnt     = gnt_en;
            if (tcdm_rsp.p_valid && rsp_cnt < 16) begin
                rsp_data[rsp_cnt] = tcdm_rsp.p.data;
                rsp_cyc[rsp_cnt]  = cyc;
                rsp_cnt++;
            end
            rd_pend = 1'b0;
            if (hwpe_if.req && hwpe_if.gnt && log_cnt < 64) begin
                log_add[log_cnt]  = hwpe_if.add;
                log_wen[log_cnt]  = hwpe_if.wen;
                log_be[log_cnt]   = hwpe_if.be;
                log_data[log_cnt] = hwpe_if.data;
                log_cyc[log_cnt]  = cyc;
                log_cnt++;
                if (hwpe_if.wen) begin
                    rd_pend = 1'b1;
                    rd_word = mem.exists(hwpe_if.add) ? mem[hwpe_if.add] : 32'h0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_q(input logic [47:0] addr, input logic wr, input logic [63:0] data,
                           input logic [7:0] strb);
        tcdm_req.q.addr  = addr;
        tcdm_req.q.write = wr;
        tcdm_req.q.amo   = 4'h0;
        tcdm_req.q.data  = data;
        tcdm_req.q.strb  = strb;
        tcdm_req.q.user  = 1'b0;
        tcdm_req.q_valid = 1'b1;
    endtask

    task automatic send(input logic [47:0] addr, input logic wr, input logic [63:0] data,
                        input logic [7:0] strb, output int hs);
        int n;
        drive_q(addr, wr, data, strb);
        n = 0;
        while (!tcdm_rsp.q_ready && n < 100) begin
            tick();
            n++;
        end
        check("q_accept", tcdm_rsp.q_ready, 1'b1);
        hs = cyc;
        tick();
        tcdm_req.q_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int target);
        int n;
        n = 0;
        while (rsp_cnt < target && n < 200) begin
            tick();
            n++;
        end
        check("rsp_arrived", 64'(rsp_cnt >= target), 64'd1);
    endtask

    initial begin
        int hs, hs_b, hs_c, bl, br;

        mem[32'h1000_0008] = 32'hbabe_cafe;
        mem[32'h1000_000c] = 32'hc0de_f00d;
        mem[32'h1000_0020] = 32'h1111_1111;
        mem[32'h1000_0024] = 32'h2222_2222;
        mem[32'h1000_0030] = 32'h3333_3333;
        mem[32'h1000_0034] = 32'h4444_4444;
        tcdm_req = '0;

        // Reset values
        tick();
        check("rst_q_ready", tcdm_rsp.q_ready, 1'b0);
        check("rst_p_valid", tcdm_rsp.p_valid, 1'b0);
        check("rst_p_data", tcdm_rsp.p.data, 64'h0);
        check("rst_req", hwpe_if.req, 1'b0);
        check("rst_add", hwpe_if.add, 32'h0);
        check("rst_wen_be_data", {hwpe_if.wen, hwpe_if.be, hwpe_if.data}, 37'h0);
        tick();
        rst_ni = 1'b1;
        tick();
        check("post_rst_q_ready", tcdm_rsp.q_ready, 1'b1);

        // 1: immediate-grant read
        bl = log_cnt;
        br = rsp_cnt;
        send(48'h0000_1000_0008, 1'b0, 64'h0, 8'hff, hs);
        wait_rsp(br + 1);
        tick();
        tick();
        check("t1_txn_count", 64'(log_cnt - bl), 64'd2);
        check("t1_lo_add", log_add[bl], 32'h1000_0008);
        check("t1_hi_add", log_add[bl+1], 32'h1000_000c);
        check("t1_wen", {log_wen[bl], log_wen[bl+1]}, 2'b11);
        check("t1_lo_cycle", 64'(log_cyc[bl] - hs), 64'd2);
        check("t1_hi_cycle", 64'(log_cyc[bl+1] - hs), 64'd3);
        check("t1_p_cycle", 64'(rsp_cyc[br] - hs), 64'd5);
        check("t1_p_data", rsp_data[br], 64'hc0de_f00d_babe_cafe);
        check("t1_single_p", 64'(rsp_cnt - br), 64'd1);

        // 2: write with upper strobe nibble only
        bl = log_cnt;
        br = rsp_cnt;
        send(48'h0000_1000_0010, 1'b1, 64'h1111_2222_3333_4444, 8'hf0, hs);
        wait_rsp(br + 1);
        tick();
        tick();
        check("t2_p_data", rsp_data[br], 64'h0);
        check("t2_single_p", 64'(rsp_cnt - br), 64'd1);
`ifdef SNAX_REQRSP_TO_HWPE_STRB_SKIP_EN
        check("t2_txn_count", 64'(log_cnt - bl), 64'd1);
        check("t2_hi_add", log_add[bl], 32'h1000_0014);
        check("t2_hi_wen_be", {log_wen[bl], log_be[bl]}, 5'h0f);
        check("t2_hi_data", log_data[bl], 32'h1111_2222);
        check("t2_p_cycle", 64'(rsp_cyc[br] - hs), 64'd3);
`else
        check("t2_txn_count", 64'(log_cnt - bl), 64'd2);
        check("t2_lo_add", log_add[bl], 32'h1000_0010);
        check("t2_lo_wen_be", {log_wen[bl], log_be[bl]}, 5'h00);
        check("t2_lo_data", log_data[bl], 32'h3333_4444);
        check("t2_hi_add", log_add[bl+1], 32'h1000_0014);
        check("t2_hi_wen_be", {log_wen[bl+1], log_be[bl+1]}, 5'h0f);
        check("t2_hi_data", log_data[bl+1], 32'h1111_2222);
        check("t2_p_cycle", 64'(rsp_cyc[br] - hs), 64'd4);
`endif

        // 3: LO grant withheld for three cycles
        bl = log_cnt;
        br = rsp_cnt;
        gnt_en = 1'b0;
        send(48'h0000_1000_0008, 1'b0, 64'h0, 8'hff, hs);
        tick();
        for (int i = 0; i < 4; i++) begin
            check("t3_lo_req_held", {hwpe_if.req, hwpe_if.wen, hwpe_if.be}, 6'b11_1111);
            check("t3_lo_add_held", hwpe_if.add, 32'h1000_0008);
            if (i == 3) gnt_en = 1'b1;
            tick();
        end
        wait_rsp(br + 1);
        check("t3_lo_first", log_add[bl], 32'h1000_0008);
        check("t3_lo_gnt_cycle", 64'(log_cyc[bl] - hs), 64'd5);
        check("t3_hi_gnt_cycle", 64'(log_cyc[bl+1] - hs), 64'd6);
        check("t3_p_cycle", 64'(rsp_cyc[br] - hs), 64'd8);
        check("t3_p_data", rsp_data[br], 64'hc0de_f00d_babe_cafe);

        // 4: three reads against a depth-2 FIFO with the grant stalled
        br = rsp_cnt;
        gnt_en = 1'b0;
        send(48'h0000_1000_0008, 1'b0, 64'h0, 8'hff, hs);
        send(48'h0000_1000_0020, 1'b0, 64'h0, 8'hff, hs_b);
        check("t4_b_back_to_back", 64'(hs_b - hs), 64'd1);
        drive_q(48'h0000_1000_0030, 1'b0, 64'h0, 8'hff);
        check("t4_full_ready_low", tcdm_rsp.q_ready, 1'b0);
        tick();
        tick();
        check("t4_full_ready_still_low", tcdm_rsp.q_ready, 1'b0);
        gnt_en = 1'b1;
        send(48'h0000_1000_0030, 1'b0, 64'h0, 8'hff, hs_c);
        wait_rsp(br + 3);
        check("t4_p0_data", rsp_data[br], 64'hc0de_f00d_babe_cafe);
        check("t4_p1_data", rsp_data[br+1], 64'h2222_2222_1111_1111);
        check("t4_p2_data", rsp_data[br+2], 64'h4444_4444_3333_3333);

        // 5: reset while the HI half is requesting, then a stray r_valid
        br = rsp_cnt;
        send(48'h0000_1000_0008, 1'b0, 64'h0, 8'hff, hs);
        tick();
        tick();
        check("t5_in_hi", {hwpe_if.req, hwpe_if.add}, {1'b1, 32'h1000_000c});
        rst_ni = 1'b0;
        #1;
        check("t5_rst_req", hwpe_if.req, 1'b0);
        check("t5_rst_add", hwpe_if.add, 32'h0);
        check("t5_rst_q_ready", tcdm_rsp.q_ready, 1'b0);
        check("t5_rst_p_valid", tcdm_rsp.p_valid, 1'b0);
        tick();
        tick();
        rst_ni       = 1'b1;
        force_rvalid = 1'b1;
        tick();
        force_rvalid = 1'b0;
        tick();
        tick();
        tick();
        check("t5_no_orphan_rsp", 64'(rsp_cnt - br), 64'd0);
        send(48'h0000_1000_0020, 1'b0, 64'h0, 8'hff, hs);
        wait_rsp(br + 1);
        check("t5_p_data", rsp_data[br], 64'h2222_2222_1111_1111);
        check("t5_p_cycle", 64'(rsp_cyc[br] - hs), 64'd5);

        // 6: write with all strobes clear
        bl = log_cnt;
        br = rsp_cnt;
        send(48'h0000_1000_0040, 1'b1, 64'hffff_ffff_ffff_ffff, 8'h00, hs);
        wait_rsp(br + 1);
        tick();
        tick();
        check("t6_p_data", rsp_data[br], 64'h0);
        check("t6_single_p", 64'(rsp_cnt - br), 64'd1);
`ifdef SNAX_REQRSP_TO_HWPE_STRB_SKIP_EN
        check("t6_txn_count", 64'(log_cnt - bl), 64'd0);
        check("t6_p_cycle", 64'(rsp_cyc[br] - hs), 64'd2);
`else
        check("t6_txn_count", 64'(log_cnt - bl), 64'd2);
        check("t6_be", {log_be[bl], log_be[bl+1]}, 8'h00);
        check("t6_p_cycle", 64'(rsp_cyc[br] - hs), 64'd4);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
